// File: rtl/fifo_tx_pkg.sv
// Shared types and line levels for the FIFO-fed serial transmitter.
package fifo_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_START = 3'd3,
    ST_DATA  = 3'd4,
    ST_STOP  = 3'd5
  } tx_state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/tx_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and ticks on the last count of each bit.
module tx_baud_gen #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic bit_tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  always_comb begin
    count_next = count_reg + 1'b1;
    if (clear || bit_tick) begin
      count_next = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign bit_tick = !clear && (count_reg == LAST_COUNT);

endmodule

// File: rtl/fifo_tx_serializer.sv
// Pulls words from an upstream FIFO and sends each as a start/data/stop serial frame, LSB first.
module fifo_tx_serializer
  import fifo_tx_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_read,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int BIT_CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);

  tx_state_t             state_reg;
  tx_state_t             state_next;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] shift_next;
  logic [BIT_CNT_W-1:0]  bit_cnt_reg;
  logic [BIT_CNT_W-1:0]  bit_cnt_next;
  logic                  baud_clear;
  logic                  bit_tick;
  logic                  start_ok;

  assign start_ok = enable && !fifo_empty;

  // Hold the bit timer at zero until the start bit begins so every bit is a full period.
  assign baud_clear = (state_reg == ST_IDLE) || (state_reg == ST_FETCH) ||
                      (state_reg == ST_LOAD);

  tx_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_gen (
    .clock   (clock),
    .reset   (reset),
    .clear   (baud_clear),
    .bit_tick(bit_tick)
  );

  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    bit_cnt_next = bit_cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start_ok) begin
          state_next = ST_FETCH;
        end
      end
      ST_FETCH: begin
        state_next = ST_LOAD;
      end
      ST_LOAD: begin
        shift_next   = fifo_data;
        bit_cnt_next = '0;
        state_next   = ST_START;
      end
      ST_START: begin
        if (bit_tick) begin
          state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_tick) begin
          shift_next   = shift_reg >> 1;
          bit_cnt_next = bit_cnt_reg + 1'b1;
          if (bit_cnt_reg == LAST_BIT) begin
            state_next = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (bit_tick) begin
          state_next = start_ok ? ST_FETCH : ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg   <= ST_IDLE;
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      bit_cnt_reg <= bit_cnt_next;
    end
  end

  // Outputs decode registered state only, so reset drives tx high without waiting for a clock.
  always_comb begin
    case (state_reg)
      ST_START: tx = START_BIT;
      ST_DATA:  tx = shift_reg[0];
      default:  tx = STOP_BIT;
    endcase
  end

  assign fifo_read  = (state_reg == ST_FETCH);
  assign busy       = (state_reg != ST_IDLE);
  assign frame_done = (state_reg == ST_STOP) && bit_tick;

endmodule

// File: tb/tb_fifo_tx_serializer.sv
// Directed bench for fifo_tx_serializer: a CLKS_PER_BIT=4 instance fed by a small FIFO model, and a CLKS_PER_BIT=3 instance.
module tb_fifo_tx_serializer;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       fifo_empty;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_read;
  logic       tx;
  logic       busy;
  logic       frame_done;

  logic       enable3 = 1'b0;
  logic       fifo_empty3 = 1'b1;
  logic [7:0] fifo_data3 = 8'h55;
  logic       fifo_read3;
  logic       tx3;
  logic       busy3;
  logic       frame_done3;

  int errors = 0;
  int checks = 0;

  logic [7:0] fifo_mem [0:15];
  logic [3:0] wr_ptr = 4'd0;
  logic [3:0] rd_ptr = 4'd0;
  int         read_count = 0;

  always #5 clock = ~clock;

  fifo_tx_serializer #(.DATA_WIDTH(8), .CLKS_PER_BIT(4)) u_dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_read (fifo_read),
    .tx        (tx),
    .busy      (busy),
    .frame_done(frame_done)
  );

  fifo_tx_serializer #(.DATA_WIDTH(8), .CLKS_PER_BIT(3)) u_dut3 (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable3),
    .fifo_empty(fifo_empty3),
    .fifo_data (fifo_data3),
    .fifo_read (fifo_read3),
    .tx        (tx3),
    .busy      (busy3),
    .frame_done(frame_done3)
  );

  // Upstream FIFO with registered read data, valid the cycle after the strobe.
  assign fifo_empty = (rd_ptr == wr_ptr);
  always @(posedge clock) begin
    if (fifo_read) begin
      fifo_data  <= fifo_mem[rd_ptr];
      rd_ptr     <= rd_ptr + 4'd1;
      read_count <= read_count + 1;
    end
  end

  task automatic push(input logic [7:0] b);
    fifo_mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 4'd1;
  endtask

  function automatic logic [63:0] frame_wave(input logic [7:0] b, input int cpb);
    logic [63:0] w;
    int k;
    w = '0;
    for (int i = 0; i < 10 * cpb; i++) begin
      k = i / cpb;
      if (k == 0)      w[i] = 1'b0;
      else if (k == 9) w[i] = 1'b1;
      else             w[i] = b[k-1];
    end
    return w;
  endfunction

  task automatic wait_read(input int max_cycles, output bit ok, output int waited);
    ok = 1'b0;
    waited = 0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clock);
      waited = i + 1;
      if (fifo_read) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic capture(input int n, input int drop_at, output logic [63:0] tx_s,
                         output logic [63:0] done_s, output logic [63:0] busy_s);
    tx_s = '0;
    done_s = '0;
    busy_s = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      tx_s[i]   = tx;
      done_s[i] = frame_done;
      busy_s[i] = busy;
      if (i == drop_at) enable = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
    checks++; if (fifo_read !== 1'b0) begin errors++; $display("FAIL reset_fifo_read: got %b expected 0", fifo_read); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
    checks++; if (tx3 !== 1'b1 || busy3 !== 1'b0) begin errors++; $display("FAIL reset_dut3: got tx=%b busy=%b expected tx=1 busy=0", tx3, busy3); end
    reset = 1'b1;
    $display("reset released");
  endtask

  task automatic test_single_frame();
    logic [63:0] t, d, b;
    logic [9:0]  seq;
    bit ok;
    int w, rc0;
    seq = 10'b1101001010;
    rc0 = read_count;
    push(8'hA5);
    enable = 1'b1;
    wait_read(20, ok, w);
    checks++; if (!ok) begin errors++; $display("FAIL single_read: got no fifo_read in %0d cycles expected one", w); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_fetch: got %b expected 1", busy); end
    @(negedge clock);
    checks++; if (fifo_read !== 1'b0 || tx !== 1'b1) begin errors++; $display("FAIL single_load: got read=%b tx=%b expected read=0 tx=1", fifo_read, tx); end
    capture(40, -1, t, d, b);
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (t[k*4 +: 4] !== {4{seq[k]}}) begin
        errors++; $display("FAIL single_bit%0d: got %b expected %b", k, t[k*4 +: 4], {4{seq[k]}});
      end
    end
    checks++; if (d[39:0] !== 40'h80_0000_0000) begin errors++; $display("FAIL single_frame_done: got %h expected 8000000000", d[39:0]); end
    checks++; if (b[39:0] !== {40{1'b1}}) begin errors++; $display("FAIL single_busy: got %h expected ffffffffff", b[39:0]); end
    @(negedge clock);
    checks++; if (busy !== 1'b0 || tx !== 1'b1) begin errors++; $display("FAIL single_idle_after: got busy=%b tx=%b expected busy=0 tx=1", busy, tx); end
    checks++; if (read_count - rc0 !== 1) begin errors++; $display("FAIL single_read_count: got %0d expected 1", read_count - rc0); end
    enable = 1'b0;
    $display("frame 0xa5 single");
  endtask

  task automatic test_back_to_back();
    logic [63:0] t1, t2, d, b;
    bit ok;
    int w, rc0;
    rc0 = read_count;
    push(8'h00);
    push(8'hFF);
    enable = 1'b1;
    wait_read(20, ok, w);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_first_read: got no fifo_read in %0d cycles expected one", w); end
    @(negedge clock);
    capture(40, -1, t1, d, b);
    @(negedge clock);
    checks++; if (fifo_read !== 1'b1 || tx !== 1'b1) begin errors++; $display("FAIL b2b_second_read: got read=%b tx=%b expected read=1 tx=1", fifo_read, tx); end
    @(negedge clock);
    checks++; if (fifo_read !== 1'b0 || tx !== 1'b1) begin errors++; $display("FAIL b2b_load: got read=%b tx=%b expected read=0 tx=1", fifo_read, tx); end
    capture(40, -1, t2, d, b);
    checks++; if (t1[39:0] !== frame_wave(8'h00, 4) >> 0 & 64'hFF_FFFF_FFFF) begin errors++; $display("FAIL b2b_frame00: got %h expected %h", t1[39:0], frame_wave(8'h00, 4)); end
    checks++; if (t2[39:0] !== frame_wave(8'hFF, 4) & 64'hFF_FFFF_FFFF) begin errors++; $display("FAIL b2b_frameFF: got %h expected %h", t2[39:0], frame_wave(8'hFF, 4)); end
    checks++; if (d[39:0] !== 40'h80_0000_0000) begin errors++; $display("FAIL b2b_frame_done: got %h expected 8000000000", d[39:0]); end
    @(negedge clock);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_after: got busy=%b expected 0", busy); end
    checks++; if (read_count - rc0 !== 2) begin errors++; $display("FAIL b2b_read_count: got %0d expected 2", read_count - rc0); end
    enable = 1'b0;
    $display("frame 0x00 then 0xff back-to-back");
  endtask

  task automatic test_empty_fifo();
    int rc0, bad_tx, bad_busy;
    rc0 = read_count;
    bad_tx = 0;
    bad_busy = 0;
    enable = 1'b1;
    repeat (100) begin
      @(negedge clock);
      if (tx !== 1'b1) bad_tx++;
      if (busy !== 1'b0) bad_busy++;
    end
    checks++; if (read_count !== rc0) begin errors++; $display("FAIL empty_reads: got %0d reads expected 0", read_count - rc0); end
    checks++; if (bad_tx !== 0) begin errors++; $display("FAIL empty_tx: got %0d low cycles expected 0", bad_tx); end
    checks++; if (bad_busy !== 0) begin errors++; $display("FAIL empty_busy: got %0d busy cycles expected 0", bad_busy); end
    enable = 1'b0;
    $display("empty fifo 100 cycles");
  endtask

  task automatic test_enable_drop();
    logic [63:0] t, d, b;
    bit ok;
    int w, rc0, stray;
    rc0 = read_count;
    push(8'h3C);
    push(8'h77);
    enable = 1'b1;
    wait_read(20, ok, w);
    checks++; if (!ok) begin errors++; $display("FAIL drop_read: got no fifo_read in %0d cycles expected one", w); end
    @(negedge clock);
    capture(40, 13, t, d, b);
    checks++; if (t[39:0] !== frame_wave(8'h3C, 4) & 64'hFF_FFFF_FFFF) begin errors++; $display("FAIL drop_frame3C: got %h expected %h", t[39:0], frame_wave(8'h3C, 4)); end
    checks++; if (d[39:0] !== 40'h80_0000_0000) begin errors++; $display("FAIL drop_frame_done: got %h expected 8000000000", d[39:0]); end
    stray = 0;
    repeat (6) begin
      @(negedge clock);
      if (busy !== 1'b0 || fifo_read !== 1'b0) stray++;
    end
    checks++; if (stray !== 0) begin errors++; $display("FAIL drop_idle: got %0d active cycles expected 0", stray); end
    $display("frame 0x3c with enable dropped mid-frame");
    enable = 1'b1;
    wait_read(20, ok, w);
    checks++; if (!ok) begin errors++; $display("FAIL drop_resume_read: got no fifo_read in %0d cycles expected one", w); end
    @(negedge clock);
    capture(40, -1, t, d, b);
    checks++; if (t[39:0] !== frame_wave(8'h77, 4) & 64'hFF_FFFF_FFFF) begin errors++; $display("FAIL drop_frame77: got %h expected %h", t[39:0], frame_wave(8'h77, 4)); end
    checks++; if (read_count - rc0 !== 2) begin errors++; $display("FAIL drop_read_count: got %0d expected 2", read_count - rc0); end
    enable = 1'b0;
    @(negedge clock);
    $display("frame 0x77 after re-enable");
  endtask

  task automatic test_reset_mid_frame();
    logic [63:0] t, d, b;
    bit ok;
    int w, rc0;
    rc0 = read_count;
    push(8'h81);
    push(8'h99);
    enable = 1'b1;
    wait_read(20, ok, w);
    checks++; if (!ok) begin errors++; $display("FAIL rst_first_read: got no fifo_read in %0d cycles expected one", w); end
    @(negedge clock);
    repeat (26) @(negedge clock);
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL rst_bit5_before: got %b expected 0", tx); end
    reset = 1'b0;
    #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rst_tx_async: got %b expected 1", tx); end
    checks++; if (busy !== 1'b0 || fifo_read !== 1'b0) begin errors++; $display("FAIL rst_outputs: got busy=%b read=%b expected 0 0", busy, fifo_read); end
    repeat (3) @(negedge clock);
    checks++; if (read_count - rc0 !== 1) begin errors++; $display("FAIL rst_no_read: got %0d reads expected 1", read_count - rc0); end
    reset = 1'b1;
    wait_read(5, ok, w);
    checks++; if (!ok || w !== 1) begin errors++; $display("FAIL rst_restart: got ok=%0d after %0d cycles expected ok=1 after 1", ok, w); end
    @(negedge clock);
    capture(40, -1, t, d, b);
    checks++; if (t[39:0] !== frame_wave(8'h99, 4) & 64'hFF_FFFF_FFFF) begin errors++; $display("FAIL rst_frame99: got %h expected %h", t[39:0], frame_wave(8'h99, 4)); end
    checks++; if (read_count - rc0 !== 2) begin errors++; $display("FAIL rst_read_count: got %0d expected 2", read_count - rc0); end
    enable = 1'b0;
    @(negedge clock);
    $display("frame 0x81 aborted by reset, frame 0x99 sent");
  endtask

  task automatic test_wraparound();
    logic [63:0] t, d;
    bit ok;
    int reads;
    ok = 1'b0;
    reads = 0;
    t = '0;
    d = '0;
    enable3 = 1'b1;
    fifo_empty3 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (fifo_read3) begin
        ok = 1'b1;
        break;
      end
    end
    fifo_empty3 = 1'b1;
    checks++; if (!ok) begin errors++; $display("FAIL wrap_read: got no fifo_read expected one"); end
    @(negedge clock);
    checks++; if (tx3 !== 1'b1) begin errors++; $display("FAIL wrap_load: got tx=%b expected 1", tx3); end
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      t[i] = tx3;
      d[i] = frame_done3;
      if (fifo_read3) reads++;
    end
    checks++; if (t[29:0] !== frame_wave(8'h55, 3) & 64'h3FFF_FFFF) begin errors++; $display("FAIL wrap_frame55: got %h expected %h", t[29:0], frame_wave(8'h55, 3)); end
    checks++; if (d[29:0] !== 30'h2000_0000) begin errors++; $display("FAIL wrap_frame_done: got %h expected 20000000", d[29:0]); end
    checks++; if (reads !== 0) begin errors++; $display("FAIL wrap_extra_read: got %0d expected 0", reads); end
    @(negedge clock);
    checks++; if (busy3 !== 1'b0 || tx3 !== 1'b1) begin errors++; $display("FAIL wrap_idle_after: got busy=%b tx=%b expected 0 1", busy3, tx3); end
    enable3 = 1'b0;
    $display("frame 0x55 at 3 clocks per bit");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_empty_fifo();
    test_enable_drop();
    test_reset_mid_frame();
    test_wraparound();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_tx_serializer.md
FIFO_TX_SERIALIZER -- requirements
Module: fifo_tx_serializer

Interface
REQ-001 Parameter DATA_WIDTH, default 8, sets the word width read from the FIFO and serialized per frame.
REQ-002 Parameter CLKS_PER_BIT, default 4, sets the clock cycles per serial bit; legal values are 2 or greater.
REQ-003 Port clock, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port enable, input, 1 bit: when high, permits starting a new frame.
REQ-006 Port fifo_empty, input, 1 bit: empty flag from the upstream FIFO.
REQ-007 Port fifo_data, input, DATA_WIDTH bits: registered FIFO read data, valid the cycle after a read pulse.
REQ-008 Port fifo_read, output, 1 bit: one-cycle read strobe to the FIFO.
REQ-009 Port tx, output, 1 bit: serial line; idle level is high.
REQ-010 Port busy, output, 1 bit: high from the FETCH state through the end of STOP.
REQ-011 Port frame_done, output, 1 bit: one-cycle pulse in the last cycle of STOP.

Function
REQ-012 The FSM SHALL have the states IDLE, FETCH, LOAD, START, DATA and STOP.
REQ-013 IDLE -> FETCH when enable=1 and fifo_empty=0; otherwise the FSM stays in IDLE with tx=1 and fifo_read=0.
REQ-014 FETCH SHALL last one cycle with fifo_read=1, then go to LOAD; fifo_read is high in no other state.
REQ-015 LOAD SHALL last one cycle, capture fifo_data into the shift register, and clear the bit counter and baud counter, then go to START.
REQ-016 START SHALL drive tx=0 for CLKS_PER_BIT cycles, then go to DATA.
REQ-017 DATA SHALL drive tx = shift_reg[0] (LSB first).
REQ-018 In DATA, the shift register SHALL shift right by one and the bit counter SHALL increment every CLKS_PER_BIT cycles.
REQ-019 DATA -> STOP after DATA_WIDTH bits have been sent.
REQ-020 STOP SHALL drive tx=1 for CLKS_PER_BIT cycles and pulse frame_done in its final cycle.
REQ-021 STOP -> FETCH directly (back-to-back frames) if enable=1 and fifo_empty=0 in the final STOP cycle, otherwise STOP -> IDLE.
REQ-022 The baud counter SHALL be $clog2(CLKS_PER_BIT) bits wide, count 0..CLKS_PER_BIT-1, and wrap to 0 on each bit boundary.
REQ-023 The bit counter SHALL be $clog2(DATA_WIDTH+1) bits wide.
REQ-024 Frame length SHALL be (DATA_WIDTH+2)*CLKS_PER_BIT cycles; latency from the IDLE->FETCH decision to the tx falling edge SHALL be 2 cycles.
REQ-025 Deasserting enable mid-frame SHALL NOT abort the frame; enable is sampled only in IDLE and in the final STOP cycle.
REQ-026 fifo_empty rising during LOAD through STOP SHALL have no effect on the current frame.
REQ-027 tx, fifo_read and frame_done SHALL be driven from registers or from the state register only, with no combinational path from any input.

Reset
REQ-028 While reset=0, the FSM SHALL be in IDLE, with tx=1, fifo_read=0, busy=0, frame_done=0, and the shift register and all counters at 0.
REQ-029 Reset asserted mid-frame SHALL force tx=1 immediately (asynchronously) and discard the partial frame, with no FIFO read issued.
REQ-030 After reset deasserts, the first FETCH SHALL occur no earlier than the first rising edge with reset=1.

Structure
REQ-031 A package fifo_tx_pkg SHALL hold the state enum tx_state_t and the localparams for the start-bit value (0) and the stop/idle value (1).
REQ-032 The baud counter SHALL be a sub-module tx_baud_gen with parameter CLKS_PER_BIT, inputs clock, reset and clear, and a one-cycle output bit_tick.

Verification
REQ-033 Single frame: DATA_WIDTH=8, CLKS_PER_BIT=4, fifo_data=8'hA5, enable=1 -> one fifo_read pulse; tx holds each bit 4 cycles in the sequence 0,1,0,1,0,0,1,0,1,1; frame_done at cycle 40 of the frame.
REQ-034 Back-to-back: FIFO holds 8'h00 then 8'hFF -> the second fifo_read occurs one cycle after the first frame's final STOP cycle; no idle gap longer than 2 cycles; tx pattern 0,00000000,1,0,11111111,1.
REQ-035 Empty FIFO: fifo_empty=1, enable=1 for 100 cycles -> fifo_read never asserts, tx=1, busy=0.
REQ-036 Enable drop: enable falls during the 3rd data bit of 8'h3C -> the frame completes correctly, then the FSM returns to IDLE even though fifo_empty=0.
REQ-037 Reset mid-frame: reset=0 during bit 5 of 8'h81 -> tx=1 in the same cycle; after release with fifo_empty=0, a fresh frame starts with a new fifo_read.
REQ-038 Wrap-around: CLKS_PER_BIT=3 (not a power of 2), byte 8'h55 -> every bit lasts exactly 3 cycles and the frame is 30 cycles.
